// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel magnitude path: frame-walk defaults and sequencer states.
package sobel_pkg;

    localparam int unsigned DefStartAddr = 770;
    localparam int unsigned DefEndAddr   = 523518;
    localparam int unsigned DefAddrStep  = 2;
    localparam int unsigned DefAddrW     = 24;

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StPause,
        StDrain,
        StDone
    } seq_state_e;

    // Width of a counter that runs 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_w(int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sobel_frame_sequencer_if.sv
// Handshake bundle between the frame sequencer, its controller and the magnitude stage.
interface sobel_frame_sequencer_if
    import sobel_pkg::*;
#(
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned HIT_W  = 20
);

    logic              start_en;
    logic              abort;
    logic              ds_ready;
    logic              mag_hit;
    logic [ADDR_W-1:0] pixel_addr;
    logic              addr_valid;
    logic              mag_en;
    logic              busy;
    logic              done;
    logic [HIT_W-1:0]  hit_count;

    modport master (
        input  start_en, abort, ds_ready, mag_hit,
        output pixel_addr, addr_valid, mag_en, busy, done, hit_count
    );

    modport slave (
        output start_en, abort, ds_ready, mag_hit,
        input  pixel_addr, addr_valid, mag_en, busy, done, hit_count
    );

endinterface

// File: rtl/sobel_valid_delay.sv
// Delays the issued-address valid by the magnitude pipeline latency so hits can be
// attributed to real beats; clr_i flushes beats still in flight.
module sobel_valid_delay #(
    parameter int unsigned Depth = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic d_i,
    output logic q_o
);

    logic [Depth-1:0] sr_q, sr_d;

    always_comb begin
        sr_d = clr_i ? '0 : ((sr_q << 1) | Depth'(d_i));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign q_o = sr_q[Depth-1];

endmodule

// File: rtl/sobel_frame_sequencer.sv
// Walks one frame of pixel addresses in paced bursts, drains the magnitude pipeline and
// counts thresholded pixels. Outputs are registered and reflect the state acted on at each edge.
module sobel_frame_sequencer
    import sobel_pkg::*;
#(
    parameter int unsigned START_ADDR = DefStartAddr,
    parameter int unsigned END_ADDR   = DefEndAddr,
    parameter int unsigned BEATS      = 4,
    parameter int unsigned PAUSE      = 1,
    parameter int unsigned ADDR_STEP  = DefAddrStep,
    parameter int unsigned ADDR_W     = DefAddrW,
    parameter int unsigned PIPE_LAT   = 2,
    parameter int unsigned HIT_W      = 20
) (
    input logic                    clk_i,
    input logic                    rst_ni,
    sobel_frame_sequencer_if.master bus_io
);

    localparam int unsigned BeatW    = cnt_w(BEATS);
    localparam int unsigned PauseW   = cnt_w(PAUSE);
    localparam int unsigned DrainW   = cnt_w(PIPE_LAT);
    localparam int unsigned AddrExtW = ADDR_W + 1;

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] nxt_q, nxt_d;
    logic [ADDR_W-1:0] pix_q, pix_d;
    logic [BeatW-1:0]  beat_q, beat_d;
    logic [PauseW-1:0] pause_q, pause_d;
    logic [DrainW-1:0] drain_q, drain_d;
    logic              vld_q, vld_d;
    logic              mag_en_q, mag_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [HIT_W-1:0]  hit_q, hit_d;
    logic              dly_clr;
    logic              dly_valid;
    logic              last_beat;

    // One extra bit keeps the end-of-frame compare from wrapping near the top of the space.
    assign last_beat = ({1'b0, nxt_q} + AddrExtW'(ADDR_STEP)) > AddrExtW'(END_ADDR);

    always_comb begin
        state_d  = state_q;
        nxt_d    = nxt_q;
        pix_d    = pix_q;
        beat_d   = beat_q;
        pause_d  = pause_q;
        drain_d  = drain_q;
        vld_d    = 1'b0;
        mag_en_d = 1'b0;
        busy_d   = (state_q != StIdle);
        done_d   = 1'b0;
        hit_d    = hit_q;
        dly_clr  = 1'b0;

        if (dly_valid && bus_io.mag_hit && (hit_q != '1)) begin
            hit_d = hit_q + 1'b1;
        end

        if ((state_q != StIdle) && bus_io.abort) begin
            state_d = StIdle;
            dly_clr = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus_io.start_en && !bus_io.abort) begin
                        state_d = StRun;
                        nxt_d   = ADDR_W'(START_ADDR);
                        pix_d   = ADDR_W'(START_ADDR);
                        beat_d  = '0;
                        pause_d = '0;
                        drain_d = '0;
                        hit_d   = '0;
                        busy_d  = 1'b1;
                    end
                end
                StRun: begin
                    mag_en_d = 1'b1;
                    if (bus_io.ds_ready) begin
                        vld_d = 1'b1;
                        pix_d = nxt_q;
                        nxt_d = nxt_q + ADDR_W'(ADDR_STEP);
                        if (last_beat) begin
                            state_d = StDrain;
                            drain_d = '0;
                        end else if (beat_q == BeatW'(BEATS - 1)) begin
                            beat_d = '0;
                            if (PAUSE > 0) begin
                                state_d = StPause;
                                pause_d = '0;
                            end
                        end else begin
                            beat_d = beat_q + 1'b1;
                        end
                    end
                end
                StPause: begin
                    mag_en_d = 1'b1;
                    if (pause_q == PauseW'(PAUSE - 1)) begin
                        state_d = StRun;
                        pause_d = '0;
                        beat_d  = '0;
                    end else begin
                        pause_d = pause_q + 1'b1;
                    end
                end
                StDrain: begin
                    mag_en_d = 1'b1;
                    if (drain_q == DrainW'(PIPE_LAT - 1)) begin
                        state_d = StDone;
                        drain_d = '0;
                    end else begin
                        drain_d = drain_q + 1'b1;
                    end
                end
                StDone: begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            nxt_q    <= ADDR_W'(START_ADDR);
            pix_q    <= ADDR_W'(START_ADDR);
            beat_q   <= '0;
            pause_q  <= '0;
            drain_q  <= '0;
            vld_q    <= 1'b0;
            mag_en_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hit_q    <= '0;
        end else begin
            state_q  <= state_d;
            nxt_q    <= nxt_d;
            pix_q    <= pix_d;
            beat_q   <= beat_d;
            pause_q  <= pause_d;
            drain_q  <= drain_d;
            vld_q    <= vld_d;
            mag_en_q <= mag_en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            hit_q    <= hit_d;
        end
    end

    sobel_valid_delay #(
        .Depth(PIPE_LAT)
    ) u_valid_delay (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .clr_i (dly_clr),
        .d_i   (vld_d),
        .q_o   (dly_valid)
    );

    assign bus_io.pixel_addr = pix_q;
    assign bus_io.addr_valid = vld_q;
    assign bus_io.mag_en     = mag_en_q;
    assign bus_io.busy       = busy_q;
    assign bus_io.done       = done_q;
    assign bus_io.hit_count  = hit_q;

endmodule

// File: tb/tb_sobel_frame_sequencer.sv
// Self-checking bench: two sequencers (full frame and short frame with a narrow hit counter)
// driven with shared stimulus and compared against a cycle-level frame model.
module tb_sobel_frame_sequencer;

    localparam int Start   = 10;
    localparam int EndA    = 20;
    localparam int EndB    = 16;
    localparam int Step    = 2;
    localparam int Beats   = 2;
    localparam int Pause   = 1;
    localparam int PipeLat = 2;
    localparam int AddrW   = 24;
    localparam int HitWA   = 20;
    localparam int HitWB   = 2;
    localparam int MaxC    = 160;

    logic clk;
    logic rst_n;

    sobel_frame_sequencer_if #(.ADDR_W(AddrW), .HIT_W(HitWA)) bus_a ();
    sobel_frame_sequencer_if #(.ADDR_W(AddrW), .HIT_W(HitWB)) bus_b ();

    sobel_frame_sequencer #(
        .START_ADDR(Start), .END_ADDR(EndA), .BEATS(Beats), .PAUSE(Pause),
        .ADDR_STEP(Step), .ADDR_W(AddrW), .PIPE_LAT(PipeLat), .HIT_W(HitWA)
    ) u_dut_a (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus_io(bus_a)
    );

    sobel_frame_sequencer #(
        .START_ADDR(Start), .END_ADDR(EndB), .BEATS(Beats), .PAUSE(Pause),
        .ADDR_STEP(Step), .ADDR_W(AddrW), .PIPE_LAT(PipeLat), .HIT_W(HitWB)
    ) u_dut_b (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus_io(bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Stimulus patterns indexed by cycle (cycle 0 = edge sampling the start request).
    bit rdy_pat[MaxC];
    bit hit_pat[MaxC];
    bit start_pat[MaxC];
    int abort_c;

    // Observations.
    logic             ov_a[MaxC];
    logic [AddrW-1:0] oaddr_a[MaxC];
    logic             odone_a[MaxC];
    logic             obusy_a[MaxC];
    logic             omag_a[MaxC];
    logic [HitWA-1:0] ohit_a[MaxC];
    logic             ov_b[MaxC];
    logic [AddrW-1:0] oaddr_b[MaxC];
    logic             odone_b[MaxC];
    logic [HitWB-1:0] ohit_b[MaxC];

    // Model expectations.
    bit ev_a[MaxC];
    int eaddr_a[MaxC];
    int edone_a, ehits_a;
    bit ev_b[MaxC];
    int eaddr_b[MaxC];
    int edone_b, ehits_b;

    task automatic clear_pats();
        for (int k = 0; k < MaxC; k++) begin
            rdy_pat[k]   = 1'b0;
            hit_pat[k]   = 1'b0;
            start_pat[k] = 1'b0;
        end
        start_pat[0] = 1'b1;
        abort_c = -1;
    endtask

    // Frame model: walk addresses, skip pause cycles after each full burst, stop after the
    // first beat whose successor would pass the end address, then drain and finish.
    task automatic model(input bit sel_b);
        int end_addr = sel_b ? EndB : EndA;
        int hw = sel_b ? HitWB : HitWA;
        int addr = Start;
        int nb = 0;
        int c = 1;
        int last_c = -1;
        int hits = 0;
        int done_c;
        int lim;
        bit v[MaxC];
        int a[MaxC];
        for (int i = 0; i < MaxC; i++) begin
            v[i] = 1'b0;
            a[i] = 0;
        end
        while (c < MaxC - PipeLat - 4) begin
            if (abort_c >= 0 && c >= abort_c) break;
            if (rdy_pat[c]) begin
                v[c] = 1'b1;
                a[c] = addr;
                nb++;
                if (addr + Step > end_addr) begin
                    last_c = c;
                    break;
                end
                addr += Step;
                if (nb == Beats) begin
                    nb = 0;
                    c += Pause;
                end
            end
            c++;
        end
        done_c = (last_c < 0) ? -1 : last_c + PipeLat + 1;
        lim = (abort_c >= 0) ? abort_c : done_c;
        for (int k = PipeLat; k <= lim; k++) begin
            if (v[k - PipeLat] && hit_pat[k] && hits < (1 << hw) - 1) hits++;
        end
        if (sel_b) begin
            ev_b = v; eaddr_b = a; edone_b = done_c; ehits_b = hits;
        end else begin
            ev_a = v; eaddr_a = a; edone_a = done_c; ehits_a = hits;
        end
    endtask

    // Drives both sequencers with the patterns; starts and ends at posedge+1.
    task automatic run_frame(input int ncyc);
        for (int k = 0; k < ncyc; k++) begin
            bus_a.start_en = start_pat[k];
            bus_a.ds_ready = rdy_pat[k];
            bus_a.mag_hit  = hit_pat[k];
            bus_a.abort    = (k == abort_c);
            bus_b.start_en = start_pat[k];
            bus_b.ds_ready = rdy_pat[k];
            bus_b.mag_hit  = hit_pat[k];
            bus_b.abort    = (k == abort_c);
            @(posedge clk);
            #1;
            ov_a[k] = bus_a.addr_valid;  oaddr_a[k] = bus_a.pixel_addr;
            odone_a[k] = bus_a.done;     obusy_a[k] = bus_a.busy;
            omag_a[k] = bus_a.mag_en;    ohit_a[k] = bus_a.hit_count;
            ov_b[k] = bus_b.addr_valid;  oaddr_b[k] = bus_b.pixel_addr;
            odone_b[k] = bus_b.done;     ohit_b[k] = bus_b.hit_count;
        end
        bus_a.start_en = 1'b0; bus_a.ds_ready = 1'b0; bus_a.mag_hit = 1'b0; bus_a.abort = 1'b0;
        bus_b.start_en = 1'b0; bus_b.ds_ready = 1'b0; bus_b.mag_hit = 1'b0; bus_b.abort = 1'b0;
    endtask

    task automatic test_reset();
        n_chk++;
        if (bus_a.pixel_addr !== AddrW'(Start) || bus_a.addr_valid !== 1'b0 ||
            bus_a.mag_en !== 1'b0 || bus_a.busy !== 1'b0 || bus_a.done !== 1'b0 ||
            bus_a.hit_count !== '0)
            $display("FAIL reset_a: addr=%0d v=%b en=%b busy=%b done=%b hits=%0d, want %0d 0 0 0 0 0",
                     bus_a.pixel_addr, bus_a.addr_valid, bus_a.mag_en, bus_a.busy, bus_a.done,
                     bus_a.hit_count, Start);
        else n_pass++;
        n_chk++;
        if (bus_b.pixel_addr !== AddrW'(Start) || bus_b.addr_valid !== 1'b0 ||
            bus_b.busy !== 1'b0 || bus_b.hit_count !== '0)
            $display("FAIL reset_b: addr=%0d v=%b busy=%b hits=%0d", bus_b.pixel_addr,
                     bus_b.addr_valid, bus_b.busy, bus_b.hit_count);
        else n_pass++;
    endtask

    task automatic test_basic();
        clear_pats();
        for (int k = 0; k < MaxC; k++) begin rdy_pat[k] = 1'b1; hit_pat[k] = 1'b1; end
        model(1'b0);
        run_frame(edone_a + 4);
        for (int k = 1; k <= edone_a + 2; k++) begin
            n_chk++;
            if (ov_a[k] !== ev_a[k])
                $display("FAIL basic_valid c%0d: got %b want %b", k, ov_a[k], ev_a[k]);
            else n_pass++;
            if (ev_a[k]) begin
                n_chk++;
                if (oaddr_a[k] !== AddrW'(eaddr_a[k]))
                    $display("FAIL basic_addr c%0d: got %0d want %0d", k, oaddr_a[k], eaddr_a[k]);
                else n_pass++;
            end
            n_chk++;
            if (odone_a[k] !== (k == edone_a))
                $display("FAIL basic_done c%0d: got %b want %b", k, odone_a[k], k == edone_a);
            else n_pass++;
            n_chk++;
            if (obusy_a[k] !== (k <= edone_a))
                $display("FAIL basic_busy c%0d: got %b want %b", k, obusy_a[k], k <= edone_a);
            else n_pass++;
            n_chk++;
            if (omag_a[k] !== (k < edone_a))
                $display("FAIL basic_mag_en c%0d: got %b want %b", k, omag_a[k], k < edone_a);
            else n_pass++;
        end
        n_chk++;
        if (ohit_a[edone_a + 3] !== HitWA'(ehits_a))
            $display("FAIL basic_hits: got %0d want %0d", ohit_a[edone_a + 3], ehits_a);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int nv = 0;
        int ne = 0;
        int dc = -1;
        clear_pats();
        for (int k = 0; k < MaxC; k++) begin rdy_pat[k] = 1'b1; hit_pat[k] = 1'b1; end
        rdy_pat[2] = 1'b0;
        rdy_pat[3] = 1'b0;
        model(1'b0);
        run_frame(edone_a + 4);
        for (int k = 1; k < edone_a + 4; k++) begin
            if (ov_a[k] === 1'b1) nv++;
            if (ev_a[k]) ne++;
            if (odone_a[k] === 1'b1 && dc < 0) dc = k;
            n_chk++;
            if (ov_a[k] !== ev_a[k])
                $display("FAIL bp_valid c%0d: got %b want %b", k, ov_a[k], ev_a[k]);
            else n_pass++;
        end
        n_chk++;
        if (nv != ne) $display("FAIL bp_beat_count: got %0d want %0d", nv, ne);
        else n_pass++;
        n_chk++;
        if (oaddr_a[4] !== AddrW'(eaddr_a[4]))
            $display("FAIL bp_held_addr: got %0d want %0d", oaddr_a[4], eaddr_a[4]);
        else n_pass++;
        n_chk++;
        if (dc != edone_a) $display("FAIL bp_done_cycle: got %0d want %0d", dc, edone_a);
        else n_pass++;
    endtask

    task automatic test_mid_burst_end();
        int dc = -1;
        clear_pats();
        for (int k = 0; k < MaxC; k++) begin rdy_pat[k] = 1'b1; hit_pat[k] = 1'b1; end
        model(1'b1);
        run_frame(edone_b + 4);
        for (int k = 1; k <= edone_b + 2; k++) begin
            if (odone_b[k] === 1'b1 && dc < 0) dc = k;
            n_chk++;
            if (ov_b[k] !== ev_b[k] || (ev_b[k] && oaddr_b[k] !== AddrW'(eaddr_b[k])))
                $display("FAIL end_beat c%0d: got v=%b a=%0d want v=%b a=%0d", k, ov_b[k],
                         oaddr_b[k], ev_b[k], eaddr_b[k]);
            else n_pass++;
        end
        n_chk++;
        if (dc != edone_b) $display("FAIL end_done_cycle: got %0d want %0d", dc, edone_b);
        else n_pass++;
        n_chk++;
        if (ohit_b[edone_b + 3] !== HitWB'(ehits_b))
            $display("FAIL end_hits_saturate: got %0d want %0d", ohit_b[edone_b + 3], ehits_b);
        else n_pass++;
    endtask

    task automatic test_hit_filter();
        clear_pats();
        for (int k = 0; k < MaxC; k++) begin rdy_pat[k] = 1'b1; hit_pat[k] = (k % 2 == 0); end
        model(1'b0);
        run_frame(edone_a + 4);
        n_chk++;
        if (ohit_a[edone_a + 3] !== HitWA'(ehits_a))
            $display("FAIL hit_filter: got %0d want %0d", ohit_a[edone_a + 3], ehits_a);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int lim;
            clear_pats();
            for (int k = 1; k < MaxC; k++) begin
                rdy_pat[k] = (k >= 60) ? 1'b1 : ($urandom_range(0, 3) != 0);
                hit_pat[k] = $urandom_range(0, 1) != 0;
            end
            model(1'b0);
            model(1'b1);
            lim = (edone_a < edone_b) ? edone_a : edone_b;
            for (int k = 1; k <= lim; k++) start_pat[k] = ($urandom_range(0, 4) == 0);
            run_frame(edone_a + 4);
            for (int s = 0; s < 2; s++) begin
                int ed = (s != 0) ? edone_b : edone_a;
                int eh = (s != 0) ? ehits_b : ehits_a;
                logic [31:0] h;
                for (int k = 1; k <= ed + 1; k++) begin
                    logic v, d;
                    logic [AddrW-1:0] a;
                    bit e;
                    int ea;
                    v = (s != 0) ? ov_b[k] : ov_a[k];
                    d = (s != 0) ? odone_b[k] : odone_a[k];
                    a = (s != 0) ? oaddr_b[k] : oaddr_a[k];
                    e = (s != 0) ? ev_b[k] : ev_a[k];
                    ea = (s != 0) ? eaddr_b[k] : eaddr_a[k];
                    n_chk++;
                    if (v !== e || (e && a !== AddrW'(ea)) || d !== (k == ed))
                        $display("FAIL rand%0d_dut%0d c%0d: got v=%b a=%0d done=%b want v=%b a=%0d done=%b",
                                 it, s, k, v, a, d, e, ea, k == ed);
                    else n_pass++;
                end
                h = (s != 0) ? 32'(ohit_b[ed + 2]) : 32'(ohit_a[ed + 2]);
                n_chk++;
                if (h !== 32'(eh)) $display("FAIL rand%0d_dut%0d_hits: got %0d want %0d", it, s, h, eh);
                else n_pass++;
            end
        end
    endtask

    task automatic test_back_to_back();
        int d;
        clear_pats();
        for (int k = 0; k < MaxC; k++) begin rdy_pat[k] = 1'b1; hit_pat[k] = 1'b1; end
        model(1'b0);
        d = edone_a;
        start_pat[d + 1] = 1'b1;
        run_frame(2 * (d + 1) + 3);
        for (int j = 1; j <= d; j++) begin
            n_chk++;
            if (ov_a[d + 1 + j] !== ev_a[j] || odone_a[d + 1 + j] !== (j == d))
                $display("FAIL b2b c%0d: got v=%b done=%b want v=%b done=%b", d + 1 + j,
                         ov_a[d + 1 + j], odone_a[d + 1 + j], ev_a[j], j == d);
            else n_pass++;
        end
        n_chk++;
        if (ohit_a[2 * d + 2] !== HitWA'(ehits_a))
            $display("FAIL b2b_hits: got %0d want %0d", ohit_a[2 * d + 2], ehits_a);
        else n_pass++;
    endtask

    task automatic test_abort();
        clear_pats();
        for (int k = 0; k < MaxC; k++) begin rdy_pat[k] = 1'b1; hit_pat[k] = 1'b1; end
        abort_c = 5;
        model(1'b0);
        run_frame(15);
        n_chk++;
        if (ohit_a[5] !== HitWA'(ehits_a))
            $display("FAIL abort_hits_at_abort: got %0d want %0d", ohit_a[5], ehits_a);
        else n_pass++;
        for (int k = 6; k < 15; k++) begin
            n_chk++;
            if (obusy_a[k] !== 1'b0 || ov_a[k] !== 1'b0 || odone_a[k] !== 1'b0 ||
                ohit_a[k] !== HitWA'(ehits_a))
                $display("FAIL abort_idle c%0d: got busy=%b v=%b done=%b hits=%0d want 0 0 0 %0d",
                         k, obusy_a[k], ov_a[k], odone_a[k], ohit_a[k], ehits_a);
            else n_pass++;
        end
        clear_pats();
        for (int k = 0; k < MaxC; k++) begin rdy_pat[k] = 1'b1; hit_pat[k] = 1'b1; end
        model(1'b0);
        run_frame(edone_a + 3);
        n_chk++;
        if (ohit_a[0] !== '0) $display("FAIL abort_restart_clear: got %0d want 0", ohit_a[0]);
        else n_pass++;
        n_chk++;
        if (ohit_a[edone_a + 2] !== HitWA'(ehits_a))
            $display("FAIL abort_restart_hits: got %0d want %0d", ohit_a[edone_a + 2], ehits_a);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        // Run into the second pause, then drop reset between clock edges.
        for (int k = 0; k <= 5; k++) begin
            bus_a.start_en = (k == 0);
            bus_a.ds_ready = 1'b1;
            bus_a.mag_hit  = 1'b1;
            @(posedge clk);
            #1;
        end
        bus_a.start_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (bus_a.pixel_addr !== AddrW'(Start) || bus_a.addr_valid !== 1'b0 ||
            bus_a.mag_en !== 1'b0 || bus_a.busy !== 1'b0 || bus_a.done !== 1'b0 ||
            bus_a.hit_count !== '0)
            $display("FAIL async_reset: addr=%0d v=%b en=%b busy=%b done=%b hits=%0d, want %0d 0 0 0 0 0",
                     bus_a.pixel_addr, bus_a.addr_valid, bus_a.mag_en, bus_a.busy, bus_a.done,
                     bus_a.hit_count, Start);
        else n_pass++;
        bus_a.start_en = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 bus_a.start_en = 1'b0;
        #2 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            n_chk++;
            if (bus_a.busy !== 1'b0 || bus_a.addr_valid !== 1'b0)
                $display("FAIL reset_start_ignored c%0d: got busy=%b v=%b want 0 0", k,
                         bus_a.busy, bus_a.addr_valid);
            else n_pass++;
        end
        bus_a.ds_ready = 1'b0;
        bus_a.mag_hit  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        bus_a.start_en = 1'b0; bus_a.abort = 1'b0; bus_a.ds_ready = 1'b0; bus_a.mag_hit = 1'b0;
        bus_b.start_en = 1'b0; bus_b.abort = 1'b0; bus_b.ds_ready = 1'b0; bus_b.mag_hit = 1'b0;
        #12;
        test_reset();
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_basic();
        test_backpressure();
        test_mid_burst_end();
        test_hit_filter();
        test_random();
        test_back_to_back();
        test_abort();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sobel_frame_sequencer.md
Name: sobel_frame_sequencer

Overview:
Sequences one frame through the Sobel magnitude stage. After a start pulse it walks the pixel address range in bursts of BEATS with PAUSE idle cycles between bursts, and stalls on downstream back-pressure. It enables the magnitude register stage, waits for the pipeline to drain, and counts pixels whose threshold flag is set. It replaces the free-running beat counter in front of the magnitude datapath with a handshaked, abortable controller.

Parameters:
START_ADDR, 770, first pixel address issued (two rows and two columns in)
END_ADDR, 523518, last legal pixel address; no address above it is issued
BEATS, 4, addresses issued per burst (≥1)
PAUSE, 1, idle cycles between bursts (0 = no pause)
ADDR_STEP, 2, address increment per issued beat
ADDR_W, 24, address width
PIPE_LAT, 2, cycles from addr_valid to the matching mag_hit (≥1)
HIT_W, 20, hit counter width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start_en  in  1  start request; sampled only in IDLE
abort  in  1  synchronous abort; returns to IDLE
ds_ready  in  1  downstream can accept an address this cycle
mag_hit  in  1  threshold flag from the magnitude stage, PIPE_LAT cycles after addr_valid
pixel_addr  out  ADDR_W  current pixel address
addr_valid  out  1  pixel_addr issued this cycle
mag_en  out  1  enables the magnitude output register (high in RUN, PAUSE, DRAIN)
busy  out  1  not IDLE
done  out  1  one-cycle pulse at frame completion
hit_count  out  HIT_W  number of hits in the current or last frame, saturating

Behaviour:
- Reset (reset=0, async): state IDLE; pixel_addr=START_ADDR; addr_valid, mag_en, busy, done=0; hit_count=0; valid-delay pipe cleared; beat and pause counters=0.
- States: IDLE, RUN, PAUSE, DRAIN, DONE. All outputs are registered.
- IDLE: start_en=1 → RUN. On that edge: hit_count←0, pixel_addr←START_ADDR, beat counter←0.
- RUN: when ds_ready=1, addr_valid=1 for pixel_addr. The following edge advances pixel_addr by ADDR_STEP and increments the beat counter. When ds_ready=0, addr_valid=0 and the address and counters hold. No timeout.
- After the BEATS-th beat of a burst: go to PAUSE if PAUSE>0, else start the next burst in RUN.
- PAUSE: addr_valid=0 for exactly PAUSE cycles, ds_ready ignored, then RUN with beat counter=0.
- Last beat: the issued beat with pixel_addr+ADDR_STEP > END_ADDR goes to DRAIN directly, with no pause, even mid-burst. pixel_addr holds the last issued value.
- DRAIN: exactly PIPE_LAT cycles with addr_valid=0. Then DONE.
- DONE: done=1 for one cycle, mag_en=0, busy=1. Then IDLE.
- Hit counting:
  - addr_valid is delayed PIPE_LAT cycles in a shift register.
  - hit_count increments when the delayed valid=1 and mag_hit=1.
  - hit_count saturates at 2^HIT_W−1.
  - mag_hit is ignored when the delayed valid=0.
- hit_count holds its value after DONE until the next start.
- abort=1 in any non-IDLE state: next state IDLE, shift register cleared, done not pulsed, hit_count holds its partial value. abort has priority over all other transitions. In IDLE, abort is a no-op, and abort wins over a simultaneous start_en.
- start_en while busy is ignored and not queued.
- Reset mid-frame: async return to the reset values above.
- Width rules: address compare is done at ADDR_W+1 bits so END_ADDR near 2^ADDR_W−1 cannot wrap.
- Defaults give 261375 issued addresses, 770..523518.

Decomposition:
- Shared package (sobel_pkg): state enum, default START_ADDR/END_ADDR/ADDR_STEP/ADDR_W constants shared with the magnitude stage.
- One natural sub-module: sobel_valid_delay (PIPE_LAT-deep, 1-bit shift register with synchronous clear).
- Counters and FSM stay in the top.

Test Plan:
- Bench parameters for all scenarios: START=10, END=20, STEP=2, BEATS=2, PAUSE=1, PIPE_LAT=2. Cycle 0 is the edge where start_en is sampled high.
- Basic run, ds_ready=1, mag_hit=1: addr_valid in cycles 1,2,4,5,7,8 with addresses 10,12,14,16,18,20; DRAIN in cycles 9–10; done=1 only in cycle 11; hit_count=6; busy=0 from cycle 12.
- Back-pressure, ds_ready=0 in cycles 2–3: address 12 held and issued in cycle 4; total of 6 valid beats still issued; done in cycle 13.
- Mid-burst end, END=16 with PAUSE=1: beats 10,12,14,16 with no trailing pause; done exactly PIPE_LAT+1 cycles after the address-16 beat.
- Hit filtering, mag_hit toggling every cycle from cycle 0: only hits aligned to delayed valid count; expected hit_count=3 (hits at cycles 4,6,10).
- abort asserted in cycle 5: IDLE in cycle 6; done never pulses; hit_count frozen at the value counted through cycle 5; a new start_en clears it.
- Asynchronous reset=0 mid-PAUSE: all outputs are at reset values immediately, with no clock edge; start_en before reset is released is ignored.
